// File: rtl/load_store_unit.sv
// Multi-cycle RV32I load/store unit: request from execute, byte-lane memory bus, extended load writeback.
// Optional macro LSU_MISALIGN_TRAP_EN: trap misaligned halfword/word accesses instead of truncating the address.
module load_store_unit #(
    parameter int ADDR_W = 32
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              req_valid,
    output logic              req_ready,
    input  logic              req_we,
    input  logic [2:0]        req_funct3,
    input  logic [ADDR_W-1:0] req_addr,
    input  logic [31:0]       req_wdata,
    input  logic [4:0]        req_rd,
    output logic              mem_req,
    output logic              mem_we,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [31:0]       mem_wdata,
    output logic [3:0]        mem_be,
    input  logic              mem_ack,
    input  logic [31:0]       mem_rdata,
    output logic              wb_valid,
    output logic              wb_we,
    output logic [4:0]        wb_rd,
    output logic [31:0]       wb_data,
    output logic              busy,
    output logic              err
);

    typedef enum logic [1:0] {IDLE, MEM, RESP} state_t;

    state_t            state_reg, state_next;
    logic              we_reg;
    logic [2:0]        funct3_reg;
    logic [ADDR_W-1:0] addr_reg;
    logic [31:0]       wdata_reg;
    logic [4:0]        rd_reg;
    logic [31:0]       result_reg;
    logic              skip_reg;
`ifdef LSU_MISALIGN_TRAP_EN
    logic              trap_reg;
`endif

    logic        accept;
    logic        req_legal;
    logic        req_misaligned;
    logic        trap_now;
    logic        go_mem;
    logic [1:0]  lane;
    logic [3:0]  be_calc;
    logic [31:0] wdata_calc;
    logic [7:0]  rd_byte;
    logic [15:0] rd_half;
    logic [31:0] load_ext;

    assign accept = req_valid && (state_reg == IDLE);

    always_comb begin
        req_legal = 1'b0;
        case (req_funct3)
            3'b000, 3'b001, 3'b010: req_legal = 1'b1;
            3'b100, 3'b101:         req_legal = !req_we;
            default:                req_legal = 1'b0;
        endcase
    end

    // funct3[1:0] encodes size for both signed and unsigned loads: 00 byte, 01 half, 10 word.
    assign req_misaligned = ((req_funct3[1:0] == 2'b01) && req_addr[0]) ||
                            ((req_funct3[1:0] == 2'b10) && (req_addr[1:0] != 2'b00));

`ifdef LSU_MISALIGN_TRAP_EN
    assign trap_now = req_legal && req_misaligned;
`else
    assign trap_now = 1'b0;
`endif
    assign go_mem = req_legal && !trap_now;

    // State register
    always_ff @(posedge clk or posedge rst) begin
        if (rst) state_reg <= IDLE;
        else     state_reg <= state_next;
    end

    // Next-state logic
    always_comb begin
        state_next = state_reg;
        case (state_reg)
            IDLE:    if (accept) state_next = go_mem ? MEM : RESP;
            MEM:     if (mem_ack) state_next = RESP;
            RESP:    state_next = IDLE;
            default: state_next = IDLE;
        endcase
    end

    // Request latch and load-result capture
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            we_reg     <= 1'b0;
            funct3_reg <= 3'b000;
            addr_reg   <= '0;
            wdata_reg  <= 32'd0;
            rd_reg     <= 5'd0;
            result_reg <= 32'd0;
            skip_reg   <= 1'b0;
`ifdef LSU_MISALIGN_TRAP_EN
            trap_reg   <= 1'b0;
`endif
        end else if (accept) begin
            we_reg     <= req_we;
            funct3_reg <= req_funct3;
            addr_reg   <= req_addr;
            wdata_reg  <= req_wdata;
            rd_reg     <= req_rd;
            result_reg <= 32'd0;
            skip_reg   <= !go_mem;
`ifdef LSU_MISALIGN_TRAP_EN
            trap_reg   <= trap_now;
`endif
        end else if ((state_reg == MEM) && mem_ack) begin
            result_reg <= we_reg ? 32'd0 : load_ext;
        end
    end

    assign lane    = addr_reg[1:0];
    assign rd_byte = mem_rdata[{lane, 3'b000} +: 8];
    assign rd_half = mem_rdata[{lane[1], 4'b0000} +: 16];

    always_comb begin
        be_calc    = 4'b1111;
        wdata_calc = wdata_reg;
        case (funct3_reg[1:0])
            2'b00: begin
                be_calc    = 4'b0001 << lane;
                wdata_calc = {4{wdata_reg[7:0]}};
            end
            2'b01: begin
                be_calc    = 4'b0011 << {lane[1], 1'b0};
                wdata_calc = {2{wdata_reg[15:0]}};
            end
            default: begin
                be_calc    = 4'b1111;
                wdata_calc = wdata_reg;
            end
        endcase
    end

    always_comb begin
        load_ext = mem_rdata;
        case (funct3_reg)
            3'b000:  load_ext = {{24{rd_byte[7]}}, rd_byte};
            3'b001:  load_ext = {{16{rd_half[15]}}, rd_half};
            3'b100:  load_ext = {24'd0, rd_byte};
            3'b101:  load_ext = {16'd0, rd_half};
            default: load_ext = mem_rdata;
        endcase
    end

    // Output logic: everything is zero outside the state that owns it.
    always_comb begin
        req_ready = (state_reg == IDLE);
        busy      = (state_reg != IDLE);
        mem_req   = 1'b0;
        mem_we    = 1'b0;
        mem_addr  = '0;
        mem_wdata = 32'd0;
        mem_be    = 4'b0000;
        wb_valid  = 1'b0;
        wb_we     = 1'b0;
        wb_rd     = 5'd0;
        wb_data   = 32'd0;
        err       = 1'b0;
        case (state_reg)
            MEM: begin
                mem_req   = 1'b1;
                mem_we    = we_reg;
                mem_addr  = {addr_reg[ADDR_W-1:2], 2'b00};
                mem_wdata = we_reg ? wdata_calc : 32'd0;
                mem_be    = be_calc;
            end
            RESP: begin
                wb_valid = 1'b1;
                wb_we    = !we_reg && !skip_reg && (rd_reg != 5'd0);
                wb_rd    = rd_reg;
                wb_data  = result_reg;
`ifdef LSU_MISALIGN_TRAP_EN
                err      = trap_reg;
`endif
            end
            default: ;
        endcase
    end

endmodule
